// File: rtl/sprite_mem_arbiter_pkg.sv
// rtl/sprite_mem_arbiter_pkg.sv - shared types and widths for the sprite memory arbiter
package sprite_mem_arbiter_pkg;

    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 8;
    localparam int MAXLEN_W = 4;

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    // Two-requester one-hot select to requester index.
    function automatic logic oh2_to_idx(input logic [1:0] oh);
        return oh[1];
    endfunction

endpackage

// File: rtl/sprite_mem_arbiter_rr_arb2.sv
// rtl/sprite_mem_arbiter_rr_arb2.sv - two-way round-robin selector, favours the requester not granted last
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] sel
);

    always_comb begin
        sel = 2'b00;
        if (last) begin
            if (req[0])      sel = 2'b01;
            else if (req[1]) sel = 2'b10;
        end else begin
            if (req[1])      sel = 2'b10;
            else if (req[0]) sel = 2'b01;
        end
    end

endmodule

// File: rtl/sprite_mem_arbiter.sv
// rtl/sprite_mem_arbiter.sv - burst read arbiter for the sprite/palette memory, two requesters
module sprite_mem_arbiter
    import sprite_mem_arbiter_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int MAXLEN_W = sprite_mem_arbiter_pkg::MAXLEN_W
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [NREQ-1:0]     req,
    input  logic [ADDR_W-1:0]   base0,
    input  logic [ADDR_W-1:0]   base1,
    input  logic [MAXLEN_W-1:0] len0,
    input  logic [MAXLEN_W-1:0] len1,
    output logic [NREQ-1:0]     gnt,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_data,
    output logic [NREQ-1:0]     rd_valid,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_last,
    output logic                busy
);

    state_t                state_q, state_d;
    logic [NREQ-1:0]       gnt_q, gnt_d;
    logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
    logic [MAXLEN_W-1:0]   cnt_q, cnt_d;
    logic                  owner_q, owner_d;
    logic                  last_q, last_d;
    logic [NREQ-1:0]       rd_valid_q, rd_valid_d;
    logic                  rd_last_q, rd_last_d;
    logic                  busy_q, busy_d;
    logic [1:0]            sel;
    logic                  issue;

    rr_arb2 u_rr_arb2 (
        .req  (req),
        .last (last_q),
        .sel  (sel)
    );

    // Every BURST cycle presents one address; its data returns one cycle later.
    assign issue = (state_q == BURST);

    always_comb begin
        state_d    = state_q;
        gnt_d      = '0;
        mem_addr_d = mem_addr_q;
        cnt_d      = cnt_q;
        owner_d    = owner_q;
        last_d     = last_q;
        rd_valid_d = '0;
        rd_last_d  = 1'b0;

        if (issue) begin
            rd_valid_d[owner_q] = 1'b1;
            rd_last_d           = (cnt_q == '0);
        end

        case (state_q)
            IDLE: begin
                if (sel != 2'b00) begin
                    state_d    = BURST;
                    gnt_d      = sel;
                    owner_d    = oh2_to_idx(sel);
                    last_d     = oh2_to_idx(sel);
                    mem_addr_d = sel[1] ? base1 : base0;
                    cnt_d      = sel[1] ? len1 : len0;
                end
            end
            BURST: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    mem_addr_d = mem_addr_q + ADDR_W'(1);
                    cnt_d      = cnt_q - MAXLEN_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == BURST) || issue;
    end

    // Reset also drops the delayed issue flag, so an in-flight word never reports.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            mem_addr_q <= '0;
            cnt_q      <= '0;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            rd_valid_q <= '0;
            rd_last_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            mem_addr_q <= mem_addr_d;
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
            busy_q     <= busy_d;
        end
    end

    assign gnt      = gnt_q;
    assign mem_addr = mem_addr_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = mem_data;
    assign rd_last  = rd_last_q;
    assign busy     = busy_q;

endmodule
